// File: rtl/ex_issue_queue.sv
// rtl/ex_issue_queue.sv - execute-stage issue FIFO feeding the ALU with a registered writeback slot
// Optional feature: define EX_ISSUE_BYPASS_EN to let an op issued into an empty
// queue with a free writeback slot skip the FIFO and complete in one edge.
module ex_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int RD_WIDTH   = 5
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         flush_in,
    input  logic                         issue_valid_in,
    output logic                         issue_ready_out,
    input  logic [3:0]                   issue_uop_in,
    input  logic [DATA_WIDTH-1:0]        issue_a_in,
    input  logic [DATA_WIDTH-1:0]        issue_b_in,
    input  logic [RD_WIDTH-1:0]          issue_rd_in,
    output logic [DATA_WIDTH-1:0]        alu_a_out,
    output logic [DATA_WIDTH-1:0]        alu_b_out,
    output logic [3:0]                   alu_uop_out,
    input  logic [DATA_WIDTH-1:0]        alu_result_in,
    output logic                         wb_valid_out,
    input  logic                         wb_ready_in,
    output logic [DATA_WIDTH-1:0]        wb_data_out,
    output logic [RD_WIDTH-1:0]          wb_rd_out,
    output logic [$clog2(DEPTH):0]       count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 4 + 2 * DATA_WIDTH + RD_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry layout: {uop, a, b, rd}
    logic [EW-1:0]         mem_q [DEPTH];
    logic [EW-1:0]         mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [RD_WIDTH-1:0]   wb_rd_q, wb_rd_d;

    logic [EW-1:0]         head;
    logic [3:0]            head_uop;
    logic [DATA_WIDTH-1:0] head_a;
    logic [DATA_WIDTH-1:0] head_b;
    logic [RD_WIDTH-1:0]   head_rd;
    logic                  empty;
    logic                  slot_free;
    logic                  bypass;
    logic                  bypass_take;
    logic                  push;
    logic                  pop;

    assign head     = mem_q[rd_ptr_q];
    assign head_uop = head[EW-1 -: 4];
    assign head_a   = head[EW-5 -: DATA_WIDTH];
    assign head_b   = head[RD_WIDTH +: DATA_WIDTH];
    assign head_rd  = head[RD_WIDTH-1:0];

    // Handshake qualifiers; readiness comes from the registered count only,
    // so a full queue refuses a push even when it pops in the same cycle.
    always_comb begin
        empty           = (count_q == '0);
        issue_ready_out = (count_q != FULL_CNT);
        slot_free       = !wb_valid_q || wb_ready_in;
`ifdef EX_ISSUE_BYPASS_EN
        bypass          = empty && slot_free && !flush_in;
`else
        bypass          = 1'b0;
`endif
        bypass_take     = bypass && issue_valid_in;
        push            = issue_valid_in && issue_ready_out && !flush_in && !bypass_take;
        pop             = !empty && slot_free && !flush_in;
    end

    // ALU operand drive: head entry, bypassed issue fields, or zeros when idle
    always_comb begin
        alu_a_out   = '0;
        alu_b_out   = '0;
        alu_uop_out = 4'b0000;
        if (!empty) begin
            alu_a_out   = head_a;
            alu_b_out   = head_b;
            alu_uop_out = head_uop;
        end else if (bypass) begin
            alu_a_out   = issue_a_in;
            alu_b_out   = issue_b_in;
            alu_uop_out = issue_uop_in;
        end
    end

    // Next-state: FIFO storage, pointers, occupancy and writeback slot; flush wins
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;

        if (push) begin
            mem_d[wr_ptr_q] = {issue_uop_in, issue_a_in, issue_b_in, issue_rd_in};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop || bypass_take) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result_in;
            wb_rd_d    = pop ? head_rd : issue_rd_in;
        end else if (wb_ready_in) begin
            wb_valid_d = 1'b0;
        end

        if (flush_in) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            wb_valid_d = 1'b0;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign wb_valid_out = wb_valid_q;
    assign wb_data_out  = wb_data_q;
    assign wb_rd_out    = wb_rd_q;
    assign count_out    = count_q;

endmodule

// File: tb/tb_ex_issue_queue.sv
// tb/tb_ex_issue_queue.sv - self-checking bench for ex_issue_queue with an ALU model and queue-based reference
module tb_ex_issue_queue;

    localparam int DEPTH = 4;
`ifdef EX_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock_in = 1'b0;
    logic        reset_n_in;
    logic        flush_in;
    logic        issue_valid_in;
    logic        issue_ready_out;
    logic [3:0]  issue_uop_in;
    logic [31:0] issue_a_in;
    logic [31:0] issue_b_in;
    logic [4:0]  issue_rd_in;
    logic [31:0] alu_a_out;
    logic [31:0] alu_b_out;
    logic [3:0]  alu_uop_out;
    logic [31:0] alu_result_in;
    logic        wb_valid_out;
    logic        wb_ready_in;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_rd_out;
    logic [2:0]  count_out;

    int checks   = 0;
    int failures = 0;

    ex_issue_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RD_WIDTH(5)) dut (
        .clock_in        (clock_in),
        .reset_n_in      (reset_n_in),
        .flush_in        (flush_in),
        .issue_valid_in  (issue_valid_in),
        .issue_ready_out (issue_ready_out),
        .issue_uop_in    (issue_uop_in),
        .issue_a_in      (issue_a_in),
        .issue_b_in      (issue_b_in),
        .issue_rd_in     (issue_rd_in),
        .alu_a_out       (alu_a_out),
        .alu_b_out       (alu_b_out),
        .alu_uop_out     (alu_uop_out),
        .alu_result_in   (alu_result_in),
        .wb_valid_out    (wb_valid_out),
        .wb_ready_in     (wb_ready_in),
        .wb_data_out     (wb_data_out),
        .wb_rd_out       (wb_rd_out),
        .count_out       (count_out)
    );

    always #5 clock_in = ~clock_in;

    // ALU semantics by micro-opcode; unlisted codes produce zero
    function automatic logic [31:0] alu_f(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (u)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a | b;
            4'b0011: return a & b;
            4'b0100: return a ^ b;
            4'b1000: return a;
            4'b1001: return b;
            4'b1010: return {31'b0, ($signed(a) < $signed(b))};
            4'b1011: return {31'b0, (a < b)};
            4'b1101: return sa >>> b[4:0];
            4'b1110: return a >> b[4:0];
            4'b1111: return a << b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    // Combinational ALU attached to the DUT operand outputs
    always_comb alu_result_in = alu_f(alu_uop_out, alu_a_out, alu_b_out);

    typedef struct packed {
        logic [3:0]  u;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_t;

    op_t         mq[$];
    logic        wb_v_m  = 1'b0;
    logic [31:0] wb_d_m  = 32'h0;
    logic [4:0]  wb_rd_m = 5'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model at
    // posedge, check registered outputs shortly after, return at next negedge.
    task automatic step(input logic v, input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rdy, input logic fl);
        op_t         e;
        logic        sf, byp, do_pop, do_push;
        logic [3:0]  eu;
        logic [31:0] ea, eb;
        issue_valid_in = v;
        issue_uop_in   = u;
        issue_a_in     = a;
        issue_b_in     = b;
        issue_rd_in    = rd;
        wb_ready_in    = rdy;
        flush_in       = fl;
        #1;
        sf  = !wb_v_m || rdy;
        byp = BYP && (mq.size() == 0) && sf && !fl;
        eu = 4'h0; ea = 32'h0; eb = 32'h0;
        if (mq.size() != 0) begin
            eu = mq[0].u; ea = mq[0].a; eb = mq[0].b;
        end else if (byp) begin
            eu = u; ea = a; eb = b;
        end
        chk("issue_ready", issue_ready_out, mq.size() != DEPTH);
        chk("alu_a", alu_a_out, ea);
        chk("alu_b", alu_b_out, eb);
        chk("alu_uop", alu_uop_out, eu);
        @(posedge clock_in);
        if (fl) begin
            mq.delete();
            wb_v_m = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && sf;
            do_push = v && (mq.size() != DEPTH) && !byp;
            if (do_pop) begin
                e = mq.pop_front();
                wb_d_m = alu_f(e.u, e.a, e.b); wb_rd_m = e.rd; wb_v_m = 1'b1;
            end else if (byp && v) begin
                wb_d_m = alu_f(u, a, b); wb_rd_m = rd; wb_v_m = 1'b1;
            end else if (rdy) begin
                wb_v_m = 1'b0;
            end
            if (do_push) mq.push_back('{u: u, a: a, b: b, rd: rd});
        end
        #1;
        chk("count", count_out, mq.size());
        chk("wb_valid", wb_valid_out, wb_v_m);
        if (wb_v_m) begin
            chk("wb_data", wb_data_out, wb_d_m);
            chk("wb_rd", wb_rd_out, wb_rd_m);
        end
        @(negedge clock_in);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 4'h0, 32'h0, 32'h0, 5'h0, rdy, 1'b0);
    endtask

    logic [31:0] drain_exp [4];

    initial begin
        drain_exp[0] = 32'h30; drain_exp[1] = 32'h2; drain_exp[2] = 32'h9; drain_exp[3] = 32'h2;
        reset_n_in = 1'b0; flush_in = 1'b0; issue_valid_in = 1'b0; issue_uop_in = 4'h0;
        issue_a_in = 32'h0; issue_b_in = 32'h0; issue_rd_in = 5'h0; wb_ready_in = 1'b0;
        #1;
        chk("rst_count", count_out, 0);
        chk("rst_wb_valid", wb_valid_out, 0);
        chk("rst_wb_data", wb_data_out, 0);
        chk("rst_wb_rd", wb_rd_out, 0);
        @(negedge clock_in);
        reset_n_in = 1'b1;
        #1;
        chk("rst_ready", issue_ready_out, 1);

        // Single ADD 5+7 -> rd 3
        step(1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
`ifdef EX_ISSUE_BYPASS_EN
        chk("single_valid_n0", wb_valid_out, 1);
        chk("single_data_n0", wb_data_out, 12);
        chk("single_rd_n0", wb_rd_out, 3);
        idle(1'b1);
`else
        chk("single_valid_n0", wb_valid_out, 0);
        idle(1'b1);
        chk("single_valid_n1", wb_valid_out, 1);
        chk("single_data_n1", wb_data_out, 12);
        chk("single_rd_n1", wb_rd_out, 3);
`endif
        idle(1'b1);

        // Backpressure fills the queue behind a held writeback slot
        step(1'b1, 4'b0001, 32'd10, 32'd4, 5'd1, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 32'hF0, 32'h3C, 5'd2, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 32'd1, 32'd3, 5'd3, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd8, 32'd1, 5'd4, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd2, 32'd2, 5'd5, 1'b0, 1'b0);
        chk("bp_count", count_out, 4);
        chk("bp_ready", issue_ready_out, 0);
        chk("bp_hold", wb_data_out, 6);
        step(1'b1, 4'b0000, 32'd100, 32'd100, 5'd6, 1'b0, 1'b0);
        chk("bp_hold2", wb_data_out, 6);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("bp_drain", wb_data_out, drain_exp[i]);
        end
        idle(1'b1);
        chk("bp_empty", wb_valid_out, 0);

        // Continuous stream wraps the pointers
        for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, i, i, 5'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Push and pop together at count 2, then at full
        for (int k = 0; k < 8 && mq.size() < 2; k++) step(1'b1, 4'b0000, k, 32'd1, 5'd1, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 32'd9, 32'd3, 5'd2, 1'b1, 1'b0);
        chk("pp_count2", count_out, 2);
        for (int k = 0; k < 8 && mq.size() < 4; k++) step(1'b1, 4'b0010, k, 32'd4, 5'd3, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 32'd7, 32'd7, 5'd4, 1'b1, 1'b0);
        chk("pp_full_pop", count_out, 3);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Flush with entries queued and slot valid
        for (int k = 0; k < 8 && mq.size() < 2; k++) step(1'b1, 4'b1111, k, 32'd2, 5'd7, 1'b0, 1'b0);
        chk("fl_pre_valid", wb_valid_out, 1);
        step(1'b1, 4'b0000, 32'd1, 32'd1, 5'd1, 1'b0, 1'b1);
        chk("fl_count", count_out, 0);
        chk("fl_valid", wb_valid_out, 0);
        issue_valid_in = 1'b0; issue_uop_in = 4'h0; issue_a_in = 32'h0; issue_b_in = 32'h0; flush_in = 1'b0;
        #1;
        chk("fl_alu_uop", alu_uop_out, 0);
        @(negedge clock_in);
        idle(1'b1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 4'($urandom), $urandom, $urandom, 5'($urandom),
                 ($urandom % 3) != 0, ($urandom % 32) == 0);
        end

        // Asynchronous reset in the middle of traffic
        for (int k = 0; k < 10 && mq.size() < 3; k++) step(1'b1, 4'b0000, k, 32'd3, 5'd9, 1'b0, 1'b0);
        chk("ar_pre_count", count_out, 3);
        chk("ar_pre_valid", wb_valid_out, 1);
        issue_valid_in = 1'b0;
        #2;
        reset_n_in = 1'b0;
        #1;
        chk("ar_count", count_out, 0);
        chk("ar_valid", wb_valid_out, 0);
        chk("ar_data", wb_data_out, 0);
        mq.delete();
        wb_v_m = 1'b0;
        @(negedge clock_in);
        reset_n_in = 1'b1;
        idle(1'b1);
        step(1'b1, 4'b0000, 32'd20, 32'd22, 5'd8, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_issue_queue.md
Name: ex_issue_queue

Overview:
- Execute-stage issue buffer that sits upstream of the ALU, between decode/operand-read and the ALU.
- Accepts decoded ALU operations over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Presents the head entry's operands and micro-opcode to the ALU, then registers the ALU result with its destination register into a single writeback slot that has its own valid/ready handshake.

Parameters:
- DATA_WIDTH, 32: operand/result width.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- RD_WIDTH, 5: destination register index width.

Ports:
- clock_in  input  1  single clock, rising edge.
- reset_n_in  input  1  reset, asynchronous, active-low.
- flush_in  input  1  synchronous flush of queue and writeback slot.
- issue_valid_in  input  1  issue request valid.
- issue_ready_out  output  1  queue can accept.
- issue_uop_in  input  4  ALU micro-opcode (0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 XOR, 1000/1001 BUFFER RS1/RS2, 1010 SLT, 1011 SLTU, 1101 SRA, 1110 SRL, 1111 SLL).
- issue_a_in  input  DATA_WIDTH  operand A (rs1).
- issue_b_in  input  DATA_WIDTH  operand B (rs2/imm).
- issue_rd_in  input  RD_WIDTH  destination register.
- alu_a_out  output  DATA_WIDTH  to ALU a_data_in.
- alu_b_out  output  DATA_WIDTH  to ALU b_data_in.
- alu_uop_out  output  4  to ALU uop_in.
- alu_result_in  input  DATA_WIDTH  from ALU result_out (combinational).
- wb_valid_out  output  1  writeback slot valid.
- wb_ready_in  input  1  writeback consumer ready.
- wb_data_out  output  DATA_WIDTH  registered result.
- wb_rd_out  output  RD_WIDTH  registered destination.
- count_out  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, reset_n_in=0): wr/rd pointers=0, count_out=0, wb_valid_out=0, wb_data_out=0, wb_rd_out=0. issue_ready_out=1 once reset deasserts.
- Push: issue_valid_in & issue_ready_out at a clock edge writes {uop,a,b,rd} at wr_ptr; wr_ptr wraps modulo DEPTH.
- issue_ready_out = (count_out != DEPTH), derived from registered count only.
  - When full, no push is accepted even if a pop occurs in the same cycle.
- slot_free = !wb_valid_out | wb_ready_in.
- Pop: (count_out != 0) & slot_free at an edge.
  - wb_data_out <= alu_result_in, wb_rd_out <= head rd, wb_valid_out <= 1; rd_ptr advances with wrap.
- wb_valid_out clears when wb_ready_in=1 and no pop occurs that edge. A slot accepted and refilled in the same edge stays at 1.
- wb_data_out and wb_rd_out hold stable while wb_valid_out=1 & wb_ready_in=0.
- ALU drive:
  - Non-empty: alu_* = head entry fields.
  - Empty: alu_a_out=0, alu_b_out=0, alu_uop_out=4'b0000.
- Latency: an op pushed at edge N appears on wb_valid_out after edge N+1, given a free slot.
- Throughput: one op per cycle sustained while wb_ready_in=1.
- Simultaneous push and pop: count unchanged. Pointers each advance.
- Flush (flush_in=1 at edge): pointers=0, count=0, wb_valid_out=0. A push or pop in the same cycle is discarded; flush has priority.
- rd=0 entries are processed normally; suppression belongs to the register file.
- Any uop value is queued unchanged; the ALU defines the result.

Optional Feature:
- Macro EX_ISSUE_BYPASS_EN.
- When defined and the queue is empty with slot_free=1:
  - Incoming issue_* fields drive alu_* combinationally.
  - A valid issue is captured directly into the writeback slot at the same edge and is not written to the FIFO, so latency = 1 edge.
- Bypass is suppressed when flush_in=1.
- When undefined: no bypass; empty-queue ALU drive is zeros as specified above; latency = 2 edges.

Test Plan:
- Reset mid-operation: with 3 entries queued and wb_valid_out=1, assert reset_n_in=0 asynchronously -> count_out=0, wb_valid_out=0, wb_data_out=0 immediately, without waiting for a clock edge.
- Single op, ADD a=5 b=7 rd=3, wb_ready_in=1, ALU model attached -> wb_valid_out=1 with wb_data_out=12, wb_rd_out=3 after edge N+1; after edge N+0 when EX_ISSUE_BYPASS_EN is defined.
- Backpressure: wb_ready_in=0, push SUB 10-4, AND 0xF0&0x3C, XOR 1^3, OR 8|1, OR 2|2 -> wb_data_out holds 6; queue reaches count_out=4 and issue_ready_out=0 (DEPTH=4). Then wb_ready_in=1 -> outputs 6,0x30,2,9,2 in order, one per cycle.
- Wrap-around: push/pop 10 ops continuously (ADD i+i, i=0..9) with wb_ready_in=1 -> results 0,2,...,18 in order, none dropped or duplicated, pointers wrap twice.
- Simultaneous push+pop at count=2 -> count stays 2. At count=4 with issue_valid_in=1 and a pop -> push refused, count becomes 3.
- Flush with 2 entries queued, wb_valid_out=1, issue_valid_in=1 -> next cycle count_out=0, wb_valid_out=0, the new op is not accepted, and alu_uop_out=0000 (no bypass).
